// File: rtl/turfio_aurora_link_sequencer.sv
// TURFIO Aurora link bring-up sequencer (init clock domain).
// Drives the Aurora GT reset and system reset in order, waits for a stable
// channel_up, retries on timeout, and gives up after MAX_RETRIES attempts.
// It re-sequences automatically whenever an established link drops.
`timescale 1ns/1ps

module turfio_aurora_link_sequencer #(
    parameter int GT_RESET_CYCLES  = 1024,
    parameter int SYS_RESET_CYCLES = 256,
    parameter int LINK_TIMEOUT     = 2**20,
    parameter int UP_STABLE_CYCLES = 64,
    parameter int MAX_RETRIES      = 8
) (
    input  logic        init_clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        force_reset_i,
    input  logic        channel_up_i,
    output logic        gt_reset_o,
    output logic        reset_o,
    output logic        link_up_o,
    output logic        fail_o,
    output logic [2:0]  state_o,
    output logic [7:0]  retry_count_o,
    output logic [15:0] drop_count_o
);

    localparam int MAX_AB    = (GT_RESET_CYCLES > SYS_RESET_CYCLES) ? GT_RESET_CYCLES : SYS_RESET_CYCLES;
    localparam int MAX_CYC   = (MAX_AB > LINK_TIMEOUT) ? MAX_AB : LINK_TIMEOUT;
    localparam int TMR_W     = $clog2(MAX_CYC) + 1;
    localparam int STB_W     = $clog2(UP_STABLE_CYCLES + 1);
    localparam int RETRY_LIM = (MAX_RETRIES > 255) ? 255 : MAX_RETRIES;

    localparam logic [TMR_W-1:0] GT_LOAD      = TMR_W'(GT_RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] SYS_LOAD     = TMR_W'(SYS_RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LOAD      = TMR_W'(LINK_TIMEOUT - 1);
    localparam logic [STB_W-1:0] STABLE_TGT   = STB_W'(UP_STABLE_CYCLES);
    localparam logic [7:0]       RETRY_LIM_V  = 8'(RETRY_LIM);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_GT_RST    = 3'd1,
        ST_SYS_RST   = 3'd2,
        ST_WAIT_LINK = 3'd3,
        ST_LINK_UP   = 3'd4,
        ST_FAILED    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [TMR_W-1:0] timer_r;
    logic [STB_W-1:0] stable_r;
    logic [7:0]       retry_r;
    logic [7:0]       retry_next_s;
    logic [7:0]       retry_inc_s;
    logic [15:0]      drop_r;
    logic [15:0]      drop_next_s;
    logic [15:0]      drop_inc_s;
    logic             load_timer_s;

    // Timer reload value for the state being entered; states without a
    // fixed duration load zero.
    function automatic logic [TMR_W-1:0] timer_load(input state_t s);
        case (s)
            ST_GT_RST:    timer_load = GT_LOAD;
            ST_SYS_RST:   timer_load = SYS_LOAD;
            ST_WAIT_LINK: timer_load = TO_LOAD;
            default:      timer_load = {TMR_W{1'b0}};
        endcase
    endfunction

    // Output decode {gt_reset, reset, link_up, fail} for a given state.
    function automatic logic [3:0] out_decode(input state_t s);
        case (s)
            ST_IDLE:      out_decode = 4'b1100;
            ST_GT_RST:    out_decode = 4'b1100;
            ST_SYS_RST:   out_decode = 4'b0100;
            ST_WAIT_LINK: out_decode = 4'b0000;
            ST_LINK_UP:   out_decode = 4'b0010;
            ST_FAILED:    out_decode = 4'b1101;
            default:      out_decode = 4'b1100;
        endcase
    endfunction

    assign retry_inc_s   = (retry_r == 8'd255) ? 8'd255 : (retry_r + 8'd1);
    assign drop_inc_s    = (drop_r == 16'hFFFF) ? 16'hFFFF : (drop_r + 16'd1);
    assign state_o       = state_r;
    assign retry_count_o = retry_r;
    assign drop_count_o  = drop_r;

    // Next-state selection: enable low beats force, force beats normal sequencing.
    always_comb begin
        next_state_s = state_r;
        load_timer_s = 1'b0;
        retry_next_s = retry_r;
        drop_next_s  = drop_r;
        if (!enable_i) begin
            next_state_s = ST_IDLE;
            retry_next_s = 8'd0;
            load_timer_s = 1'b1;
        end else if (force_reset_i) begin
            next_state_s = ST_GT_RST;
            retry_next_s = 8'd0;
            load_timer_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    next_state_s = ST_GT_RST;
                    load_timer_s = 1'b1;
                end
                ST_GT_RST: begin
                    if (timer_r == {TMR_W{1'b0}}) begin
                        next_state_s = ST_SYS_RST;
                        load_timer_s = 1'b1;
                    end else begin
                        next_state_s = ST_GT_RST;
                    end
                end
                ST_SYS_RST: begin
                    if (timer_r == {TMR_W{1'b0}}) begin
                        next_state_s = ST_WAIT_LINK;
                        load_timer_s = 1'b1;
                    end else begin
                        next_state_s = ST_SYS_RST;
                    end
                end
                ST_WAIT_LINK: begin
                    // Stable completion takes precedence over a coincident timeout.
                    if (stable_r == STABLE_TGT) begin
                        next_state_s = ST_LINK_UP;
                        retry_next_s = 8'd0;
                        load_timer_s = 1'b1;
                    end else if (timer_r == {TMR_W{1'b0}}) begin
                        retry_next_s = retry_inc_s;
                        load_timer_s = 1'b1;
                        if ((MAX_RETRIES != 0) && (retry_inc_s >= RETRY_LIM_V)) begin
                            next_state_s = ST_FAILED;
                        end else begin
                            next_state_s = ST_GT_RST;
                        end
                    end else begin
                        next_state_s = ST_WAIT_LINK;
                    end
                end
                ST_LINK_UP: begin
                    if (!channel_up_i) begin
                        next_state_s = ST_GT_RST;
                        drop_next_s  = drop_inc_s;
                        load_timer_s = 1'b1;
                    end else begin
                        next_state_s = ST_LINK_UP;
                    end
                end
                ST_FAILED: begin
                    next_state_s = ST_FAILED;
                end
                default: begin
                    next_state_s = ST_IDLE;
                    retry_next_s = 8'd0;
                    load_timer_s = 1'b1;
                end
            endcase
        end
    end

    // State, timer, counters and outputs, with outputs decoded from the new state.
    always_ff @(posedge init_clk_i) begin
        if (reset_i) begin
            state_r    <= ST_IDLE;
            timer_r    <= {TMR_W{1'b0}};
            stable_r   <= {STB_W{1'b0}};
            retry_r    <= 8'd0;
            drop_r     <= 16'd0;
            gt_reset_o <= 1'b1;
            reset_o    <= 1'b1;
            link_up_o  <= 1'b0;
            fail_o     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            {gt_reset_o, reset_o, link_up_o, fail_o} <= out_decode(next_state_s);
            retry_r <= retry_next_s;
            drop_r  <= drop_next_s;
            if (load_timer_s) begin
                timer_r <= timer_load(next_state_s);
            end else if (timer_r != {TMR_W{1'b0}}) begin
                timer_r <= timer_r - TMR_W'(1);
            end else begin
                timer_r <= timer_r;
            end
            if (load_timer_s || (state_r != ST_WAIT_LINK)) begin
                stable_r <= {STB_W{1'b0}};
            end else if (!channel_up_i) begin
                stable_r <= {STB_W{1'b0}};
            end else if (stable_r == STABLE_TGT) begin
                stable_r <= stable_r;
            end else begin
                stable_r <= stable_r + STB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_turfio_aurora_link_sequencer.sv
// Directed bench for the Aurora link sequencer with short timing parameters
// (16/8/100/4/3); all expected values are hand-derived constants.
`timescale 1ns/1ps

module tb_turfio_aurora_link_sequencer;

    logic        init_clk_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic        force_reset_i;
    logic        channel_up_i;
    logic        gt_reset_o;
    logic        reset_o;
    logic        link_up_o;
    logic        fail_o;
    logic [2:0]  state_o;
    logic [7:0]  retry_count_o;
    logic [15:0] drop_count_o;

    int check_cnt = 0;
    int fail_cnt  = 0;

    always #5 init_clk_i = ~init_clk_i;

    turfio_aurora_link_sequencer #(
        .GT_RESET_CYCLES  (16),
        .SYS_RESET_CYCLES (8),
        .LINK_TIMEOUT     (100),
        .UP_STABLE_CYCLES (4),
        .MAX_RETRIES      (3)
    ) dut (
        .init_clk_i    (init_clk_i),
        .reset_i       (reset_i),
        .enable_i      (enable_i),
        .force_reset_i (force_reset_i),
        .channel_up_i  (channel_up_i),
        .gt_reset_o    (gt_reset_o),
        .reset_o       (reset_o),
        .link_up_o     (link_up_o),
        .fail_o        (fail_o),
        .state_o       (state_o),
        .retry_count_o (retry_count_o),
        .drop_count_o  (drop_count_o)
    );

    // Single comparison point: counts and reports every check.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge init_clk_i);
        #1;
    endtask

    // Number of consecutive observations of state s, starting now (bounded).
    task automatic count_state(input logic [2:0] s, output int n);
        n = 0;
        while ((state_o == s) && (n < 1000)) begin
            n++;
            tick();
        end
    endtask

    int         n;
    logic       saw_link;
    logic [7:0] pat;

    initial begin
        reset_i       = 1'b1;
        enable_i      = 1'b0;
        force_reset_i = 1'b0;
        channel_up_i  = 1'b0;
        tick();
        tick();
        check_eq("rst_state", state_o, 32'd0);
        check_eq("rst_gt", gt_reset_o, 32'd1);
        check_eq("rst_sys", reset_o, 32'd1);
        check_eq("rst_link", link_up_o, 32'd0);
        check_eq("rst_fail", fail_o, 32'd0);
        check_eq("rst_retry", retry_count_o, 32'd0);
        check_eq("rst_drop", drop_count_o, 32'd0);
        reset_i = 1'b0;
        tick();
        check_eq("idle_hold", state_o, 32'd0);

        // Bring-up sequence timing
        enable_i = 1'b1;
        tick();
        check_eq("gt_entry", state_o, 32'd1);
        check_eq("gt_entry_sys", reset_o, 32'd1);
        count_state(3'd1, n);
        check_eq("gt_len", n, 32'd16);
        check_eq("sys_state", state_o, 32'd2);
        check_eq("sys_gt_low", gt_reset_o, 32'd0);
        check_eq("sys_rst_high", reset_o, 32'd1);
        count_state(3'd2, n);
        check_eq("sys_len", n, 32'd8);
        check_eq("wait_state", state_o, 32'd3);
        check_eq("wait_gt", gt_reset_o, 32'd0);
        check_eq("wait_rst", reset_o, 32'd0);

        // Four stable cycles, link declared on the fifth edge
        channel_up_i = 1'b1;
        repeat (4) tick();
        check_eq("link_early", link_up_o, 32'd0);
        tick();
        check_eq("link_up", link_up_o, 32'd1);
        check_eq("link_state", state_o, 32'd4);
        check_eq("link_retry", retry_count_o, 32'd0);

        // One-cycle drop from LINK_UP
        channel_up_i = 1'b0;
        tick();
        check_eq("drop_state", state_o, 32'd1);
        check_eq("drop_cnt1", drop_count_o, 32'd1);
        check_eq("drop_link", link_up_o, 32'd0);
        check_eq("drop_gt", gt_reset_o, 32'd1);
        count_state(3'd1, n);
        check_eq("gt_len2", n, 32'd16);
        count_state(3'd2, n);
        check_eq("sys_len2", n, 32'd8);

        // Interrupted stability pattern 1,1,1,0,1,1,1,1
        pat = 8'b1110_1111;
        saw_link = 1'b0;
        for (int i = 0; i < 8; i++) begin
            channel_up_i = pat[7-i];
            tick();
            if (link_up_o) saw_link = 1'b1;
        end
        check_eq("pat_no_early", saw_link, 32'd0);
        check_eq("pat_wait", state_o, 32'd3);
        tick();
        check_eq("pat_link", link_up_o, 32'd1);

        // Timeouts to FAILED
        channel_up_i = 1'b0;
        tick();
        check_eq("drop_cnt2", drop_count_o, 32'd2);
        count_state(3'd1, n);
        check_eq("gt_len3", n, 32'd16);
        count_state(3'd2, n);
        count_state(3'd3, n);
        check_eq("timeout_len", n, 32'd100);
        check_eq("timeout_state", state_o, 32'd1);
        check_eq("timeout_retry1", retry_count_o, 32'd1);
        n = 0;
        while ((state_o != 3'd5) && (n < 1000)) begin
            tick();
            n++;
        end
        check_eq("to_failed_cycles", n, 32'd248);
        check_eq("failed_flag", fail_o, 32'd1);
        check_eq("failed_retry", retry_count_o, 32'd3);
        check_eq("failed_gt", gt_reset_o, 32'd1);
        check_eq("failed_rst", reset_o, 32'd1);
        check_eq("failed_drop", drop_count_o, 32'd2);
        repeat (5) tick();
        check_eq("failed_hold", state_o, 32'd5);

        // Force restart
        force_reset_i = 1'b1;
        tick();
        force_reset_i = 1'b0;
        check_eq("force_state", state_o, 32'd1);
        check_eq("force_retry", retry_count_o, 32'd0);
        check_eq("force_fail", fail_o, 32'd0);

        // Enable dropped mid SYS_RST
        count_state(3'd1, n);
        check_eq("force_gt_len", n, 32'd16);
        tick();
        tick();
        enable_i = 1'b0;
        tick();
        check_eq("dis_state", state_o, 32'd0);
        check_eq("dis_gt", gt_reset_o, 32'd1);
        check_eq("dis_rst", reset_o, 32'd1);
        enable_i = 1'b1;
        tick();
        check_eq("reen_state", state_o, 32'd1);
        count_state(3'd1, n);
        check_eq("reen_gt_len", n, 32'd16);
        count_state(3'd2, n);
        check_eq("reen_sys_len", n, 32'd8);
        channel_up_i = 1'b1;
        repeat (5) tick();
        check_eq("reen_link", link_up_o, 32'd1);

        // reset_i while linked
        reset_i = 1'b1;
        tick();
        check_eq("lrst_state", state_o, 32'd0);
        check_eq("lrst_gt", gt_reset_o, 32'd1);
        check_eq("lrst_rst", reset_o, 32'd1);
        check_eq("lrst_link", link_up_o, 32'd0);
        check_eq("lrst_fail", fail_o, 32'd0);
        check_eq("lrst_retry", retry_count_o, 32'd0);
        check_eq("lrst_drop", drop_count_o, 32'd0);
        reset_i      = 1'b0;
        channel_up_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
